// File: rtl/cplx_rot_acc_if.sv
// Command/status bundle for the complex rotate/accumulate engine.
interface cplx_rot_acc_if #(
  parameter int W  = 16,
  parameter int CW = 8
);
  logic          ld;
  logic          st;
  logic [1:0]    mode;
  logic          acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  xre;
  logic [W-1:0]  xim;
  logic [W-1:0]  qre;
  logic [W-1:0]  qim;
  logic          busy;
  logic          done;
  logic          ovf;

  modport master (output ld, st, mode, acc, cnt, xre, xim,
                  input  qre, qim, busy, done, ovf);
  modport slave  (input  ld, st, mode, acc, cnt, xre, xim,
                  output qre, qim, busy, done, ovf);
endinterface

// File: rtl/cplx_rot_acc.sv
// Multi-step complex rotate (x j^k) / accumulate engine with start/busy/done handshake.
// Define CPLX_ROT_SAT_EN to saturate overflowing components instead of wrapping.

// Reduces one W+1-bit component to W bits and flags overflow.
module cplx_rot_red #(
  parameter int W = 16
) (
  input  logic [W:0]   v,
  output logic [W-1:0] r,
  output logic         o
);
  always_comb begin
    o = v[W] ^ v[W-1];
    r = v[W-1:0];
`ifdef CPLX_ROT_SAT_EN
    if (o) r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end
endmodule

module cplx_rot_acc #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  cplx_rot_acc_if.slave  bus
);
  localparam int NUM_LANES = 2;  // lane 0 = real, lane 1 = imag

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;

  logic [CW-1:0]        ctr;
  logic [1:0]           mode_s;
  logic                 acc_s;
  logic signed [W-1:0]  xre_s, xim_s, qre_r, qim_r;
  logic                 ovf_r;
  logic                 busy_o, done_o;

  logic signed [W:0]    sre, sim, rre, rim, nre, nim;
  logic [NUM_LANES-1:0][W:0]   wide;
  logic [NUM_LANES-1:0][W-1:0] red;
  logic [NUM_LANES-1:0]        lovf;

  function automatic logic signed [W:0] sx(input logic signed [W-1:0] a);
    return {a[W-1], a};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!bus.ld && bus.st) nxt = (bus.cnt == '0) ? DONE : RUN;
      RUN:     if (ctr == CW'(1)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decode from registered state only
  always_comb begin
    busy_o = (state == RUN);
    done_o = (state == DONE);
  end

  // One step: rotate source by j^mode at W+1 bits, optionally add to Q
  always_comb begin
    sre = acc_s ? sx(xre_s) : sx(qre_r);
    sim = acc_s ? sx(xim_s) : sx(qim_r);
    case (mode_s)
      2'd0:    begin rre = sre;  rim = sim;  end
      2'd1:    begin rre = -sim; rim = sre;  end
      2'd2:    begin rre = -sre; rim = -sim; end
      default: begin rre = sim;  rim = -sre; end
    endcase
    nre = acc_s ? sx(qre_r) + rre : rre;
    nim = acc_s ? sx(qim_r) + rim : rim;
    wide[0] = nre;
    wide[1] = nim;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    cplx_rot_red #(.W(W)) u_red (.v(wide[l]), .r(red[l]), .o(lovf[l]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qre_r  <= '0;
      qim_r  <= '0;
      ovf_r  <= 1'b0;
      ctr    <= '0;
      mode_s <= '0;
      acc_s  <= 1'b0;
      xre_s  <= '0;
      xim_s  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld) begin
            qre_r <= bus.xre;
            qim_r <= bus.xim;
            ovf_r <= 1'b0;
          end else if (bus.st) begin
            mode_s <= bus.mode;
            acc_s  <= bus.acc;
            xre_s  <= bus.xre;
            xim_s  <= bus.xim;
            ctr    <= bus.cnt;
          end
        end
        RUN: begin
          qre_r <= red[0];
          qim_r <= red[1];
          ovf_r <= ovf_r | (|lovf);
          ctr   <= ctr - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.qre  = qre_r;
  assign bus.qim  = qim_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_o;
  assign bus.done = done_o;
endmodule

// File: tb/tb_cplx_rot_acc.sv
// Self-checking bench for cplx_rot_acc: vector table + scoreboard, plus reset/noise sequences.
module tb_cplx_rot_acc;
  localparam int W  = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cplx_rot_acc_if #(.W(W), .CW(CW)) bus ();
  cplx_rot_acc #(.W(W), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int xre, xim, mode, acc, cnt;
    int eqre, eqim, eovf;
  } vec_t;

  typedef struct {
    int qre, qim, ovf, busy;
  } exp_t;

  vec_t tbl[11];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.ld = 0; bus.st = 0; bus.mode = 0; bus.acc = 0; bus.cnt = 0;
    bus.xre = 0; bus.xim = 0;
  endtask

  task automatic noise_in();
    bus.ld   = 1'($urandom_range(0, 1));
    bus.st   = 1'($urandom_range(0, 1));
    bus.mode = 2'($urandom);
    bus.acc  = 1'($urandom_range(0, 1));
    bus.cnt  = 8'($urandom);
    bus.xre  = 16'($urandom);
    bus.xim  = 16'($urandom);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_ld(input int xr, input int xi);
    bus.ld = 1; bus.xre = 16'(xr); bus.xim = 16'(xi);
    @(negedge clk);
    clear_in();
    chk("ld_qre", int'($signed(bus.qre)), xr);
    chk("ld_qim", int'($signed(bus.qim)), xi);
    chk("ld_ovf", int'(bus.ovf), 0);
  endtask

  task automatic do_st(input int md, input int ac, input int cn, input int xr, input int xi,
                       input int eqre, input int eqim, input int eovf, input bit noisy);
    int bc, lat, busy_at_done;
    bit got;
    exp_t e;
    bus.st = 1; bus.mode = 2'(md); bus.acc = 1'(ac); bus.cnt = 8'(cn);
    bus.xre = 16'(xr); bus.xim = 16'(xi);
    sb.push_back('{qre: eqre, qim: eqim, ovf: eovf, busy: cn});
    bc = 0; lat = 0; got = 0; busy_at_done = 0;
    for (int n = 1; n <= cn + 10; n++) begin
      @(negedge clk);
      if (noisy) noise_in(); else clear_in();
      if (bus.busy) bc++;
      if (bus.done) begin
        got = 1; lat = n; busy_at_done = int'(bus.busy);
        clear_in();
        break;
      end
    end
    chk("done_seen", int'(got), 1);
    e = sb.pop_front();
    chk("qre", int'($signed(bus.qre)), e.qre);
    chk("qim", int'($signed(bus.qim)), e.qim);
    chk("ovf", int'(bus.ovf), e.ovf);
    chk("busy_cycles", bc, e.busy);
    chk("done_latency", lat, cn + 1);
    chk("busy_at_done", busy_at_done, 0);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 0);
  endtask

  initial begin
    int bc;
`ifdef CPLX_ROT_SAT_EN
    localparam int OV6_RE = 32767;
    localparam int OV8_RE = 32767;
`else
    localparam int OV6_RE = -32768;
    localparam int OV8_RE = -5536;
`endif
    //          xre     xim  md ac  cnt  eqre    eqim  eovf
    tbl[0]  = '{3,      4,   1, 0,  1,   -4,     3,    0};
    tbl[1]  = '{3,      4,   1, 0,  4,   3,      4,    0};
    tbl[2]  = '{3,      4,   3, 0,  2,   -3,     -4,   0};
    tbl[3]  = '{100,    -50, 0, 1,  3,   400,    -200, 0};
    tbl[4]  = '{100,    -50, 1, 1,  1,   150,    50,   0};
    tbl[5]  = '{-32768, 0,   2, 0,  1,   OV6_RE, 0,    1};
    tbl[6]  = '{3,      4,   2, 0,  3,   -3,     -4,   0};
    tbl[7]  = '{20000,  0,   0, 1,  2,   OV8_RE, 0,    1};
    tbl[8]  = '{10,     20,  3, 1,  2,   50,     0,    0};
    tbl[9]  = '{7,      -9,  1, 0,  0,   7,      -9,   0};
    tbl[10] = '{3,      4,   1, 0,  255, 4,      -3,   0};

    clear_in();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_qre", int'($signed(bus.qre)), 0);
    chk("rst_qim", int'($signed(bus.qim)), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    rst = 0;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_ld(tbl[i].xre, tbl[i].xim);
      do_st(tbl[i].mode, tbl[i].acc, tbl[i].cnt, tbl[i].xre, tbl[i].xim,
            tbl[i].eqre, tbl[i].eqim, tbl[i].eovf, 1'b0);
    end

    // Inputs toggling during RUN/DONE must not disturb Q or the step count
    do_ld(3, 4);
    do_st(1, 0, 4, 3, 4, 3, 4, 0, 1'b1);
    do_ld(100, -50);
    do_st(0, 1, 3, 100, -50, 400, -200, 0, 1'b1);

    // Reset in the 5th busy cycle of a 10-step run
    do_ld(3, 4);
    bus.st = 1; bus.mode = 1; bus.acc = 0; bus.cnt = 10; bus.xre = 3; bus.xim = 4;
    bc = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      clear_in();
      if (bus.busy) bc++;
      if (bc == 5) break;
    end
    chk("mid_busy_count", bc, 5);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_qre", int'($signed(bus.qre)), 0);
    chk("mid_rst_qim", int'($signed(bus.qim)), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_ovf", int'(bus.ovf), 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle_busy", int'(bus.busy), 0);
    // Fresh start from Q=(0,0): accumulate j*(5,6)
    do_st(1, 1, 1, 5, 6, -6, 5, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
